// File: rtl/delayed_update_queue.sv
// Scheduled-write executor: each accepted request carries a data word and a delay,
// and is written into a single output register once the delay has elapsed.
module delayed_update_queue #(
    parameter int                DATA_W    = 16,
    parameter int                DEPTH     = 4,
    parameter int                DLY_W     = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [DATA_W-1:0]          req_data,
    input  logic [DLY_W-1:0]           req_delay,
    input  logic                       flush,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_update,
    output logic [$clog2(DEPTH+1)-1:0] pending
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Handshake: a request transfers at a rising edge where req_valid and req_ready
    // are both high; req_ready depends only on registered occupancy and flush.
    logic [DEPTH-1:0]  slot_valid;
    logic [DATA_W-1:0] slot_data  [DEPTH];
    logic [DLY_W-1:0]  slot_count [DEPTH];
    // older[i][j] set means slot i was accepted before slot j.
    logic [DEPTH-1:0]  older      [DEPTH];

    logic [DEPTH-1:0]  mature;
    logic [IDX_W-1:0]  alloc_idx;
    logic [DATA_W-1:0] win_data;
    logic [DATA_W-1:0] next_out;
    logic [CNT_W-1:0]  valid_cnt;
    logic              youngest;
    logic              accept;
    logic              accept_now;
    logic              accept_slot;
    logic              apply;

    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        mature = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mature[i] = slot_valid[i] && (slot_count[i] == DLY_W'(1));
        end
    end

    // Among slots maturing together, the most recently accepted one supplies the data.
    always_comb begin
        win_data = '0;
        youngest = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            youngest = mature[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && mature[j] && older[i][j]) begin
                    youngest = 1'b0;
                end
            end
            if (youngest) begin
                win_data = slot_data[i];
            end
        end
    end

    always_comb begin
        valid_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_cnt = valid_cnt + CNT_W'(slot_valid[i]);
        end
    end

    assign req_ready   = ~(&slot_valid) & ~flush;
    assign accept      = req_valid & req_ready;
    assign accept_now  = accept & (req_delay == '0);
    assign accept_slot = accept & (req_delay != '0);
    assign apply       = ~flush & (accept_now | (|mature));
    // A zero-delay accept is always younger than any maturing slot.
    assign next_out    = accept_now ? req_data : win_data;
    assign pending     = valid_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid <= '0;
            out_data   <= RESET_VAL;
            out_update <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_data[i]  <= '0;
                slot_count[i] <= '0;
                older[i]      <= '0;
            end
        end else if (flush) begin
            slot_valid <= '0;
            out_update <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mature[i]) begin
                    slot_valid[i] <= 1'b0;
                end else if (slot_valid[i]) begin
                    slot_count[i] <= slot_count[i] - DLY_W'(1);
                end
            end
            if (accept_slot) begin
                slot_valid[alloc_idx] <= 1'b1;
                slot_data[alloc_idx]  <= req_data;
                slot_count[alloc_idx] <= req_delay;
                older[alloc_idx]      <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (IDX_W'(j) != alloc_idx) begin
                        older[j][alloc_idx] <= 1'b1;
                    end
                end
            end
            if (apply) begin
                out_data <= next_out;
            end
            out_update <= apply;
        end
    end

endmodule
